ltc2174_spi_resp: RTL

Synthesizable SPI responder for the LTC2174 serial programming port: the chip-side end of the link driven by the `ltc2174` SPI initiator. It holds the register map in flops and decodes register fields onto ports, for the FPGA-based ADC emulator and for closed-loop driver regression. SCK, CS and SDI are oversampled in the system clock domain, and SDO is returned for reads.

---
 rtl/ltc2174_spi_pkg.sv | 33 +++
 rtl/ltc2174_spi_resp_if.sv | 19 +
 rtl/ltc2174_pin_sync.sv | 32 +++
 rtl/ltc2174_spi_resp.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ltc2174_spi_pkg.sv
// LTC2174 SPI responder: shared addresses, field layout, FSM states.
// Readback is built only when LTC2174_SPI_READBACK_EN is defined.
package ltc2174_spi_pkg;

  localparam logic [6:0] ADDR_RESET   = 7'h00;
  localparam logic [6:0] ADDR_FORMAT  = 7'h01;
  localparam logic [6:0] ADDR_OUTMODE = 7'h02;
  localparam logic [6:0] ADDR_TPMSB   = 7'h03;
  localparam logic [6:0] ADDR_TPLSB   = 7'h04;

  localparam logic [7:0] REG_RST = 8'h00;

  localparam int SOFT_RST_BIT = 7;
  localparam int DCSOFF_BIT   = 7;
  localparam int RAND_BIT     = 6;
  localparam int TWOS_BIT     = 5;
  localparam int SLEEP_W      = 5;
  localparam int ILVDS_LSB    = 5;
  localparam int ILVDS_W      = 3;
  localparam int TERMON_BIT   = 4;
  localparam int OUTOFF_BIT   = 3;
  localparam int OUTMODE_W    = 3;
  localparam int OUTTEST_BIT  = 7;
  localparam int TPMSB_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_HOLD
  } spi_st_e;

endpackage

// File: rtl/ltc2174_spi_resp_if.sv
// LTC2174 SPI pin bundle: initiator drives cs/sck/sdi, responder sdo/sdo_oe.
// sdo/sdo_oe stay 0 unless LTC2174_SPI_READBACK_EN is defined.
interface ltc2174_spi_resp_if;
  logic cs;
  logic sck;
  logic sdi;
  logic sdo;
  logic sdo_oe;

  modport master (
    output cs, sck, sdi,
    input  sdo, sdo_oe
  );

  modport slave (
    input  cs, sck, sdi,
    output sdo, sdo_oe
  );
endinterface

// File: rtl/ltc2174_pin_sync.sv
// Pin synchronizer with one history flop for rise/fall detection.
// Used for cs/sck/sdi of the LTC2174 SPI responder.
module ltc2174_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_hist;
  assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/ltc2174_spi_resp.sv
// LTC2174 SPI responder: oversampled SPI, register map A0-A4, field decode.
// Define LTC2174_SPI_READBACK_EN to build the read path (sdo/sdo_oe).
module ltc2174_spi_resp
  import ltc2174_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  ltc2174_spi_resp_if.slave   spi,
  output logic                dcsoff,
  output logic                rand_en,
  output logic                twoscomp,
  output logic [4:0]          sleep,
  output logic [2:0]          ilvds,
  output logic                termon,
  output logic                outoff,
  output logic [2:0]          outmode,
  output logic                outtest,
  output logic [13:0]         testpattern,
  output logic                soft_reset,
  output logic                wr_stb,
  output logic [6:0]          wr_addr,
  output logic [7:0]          wr_data
);

  logic w_cs_rise;
  logic w_cs_fall;
  logic w_sck_rise;
  logic w_sdi;
`ifdef LTC2174_SPI_READBACK_EN
  logic w_sck_fall;
`endif

  ltc2174_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk, .reset_n, .i_pin(spi.cs),
    .o_level(), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  ltc2174_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk, .reset_n, .i_pin(spi.sck),
    .o_level(), .o_rise(w_sck_rise),
`ifdef LTC2174_SPI_READBACK_EN
    .o_fall(w_sck_fall)
`else
    .o_fall()
`endif
  );

  ltc2174_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk, .reset_n, .i_pin(spi.sdi),
    .o_level(w_sdi), .o_rise(), .o_fall()
  );

  spi_st_e    r_state;
  logic [2:0] r_cnt;
  logic [6:0] r_sh;
  logic       r_rw;
  logic [6:0] r_addr;
  logic [7:0] r_a1, r_a2, r_a3, r_a4;
  logic       r_soft;
  logic       r_stb;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;

  logic [7:0] w_byte;
  logic       w_active;

  assign w_byte   = {r_sh, w_sdi};
  assign w_active = (r_state == ST_CMD) || (r_state == ST_DATA);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_a1      <= REG_RST;
      r_a2      <= REG_RST;
      r_a3      <= REG_RST;
      r_a4      <= REG_RST;
      r_soft    <= 1'b0;
      r_stb     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_soft <= 1'b0;
      r_stb  <= 1'b0;
      if (w_cs_fall) begin
        r_state <= ST_CMD;
        r_cnt   <= '0;
      end else if (w_sck_rise && w_active) begin
        r_sh  <= w_byte[6:0];
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          if (r_state == ST_CMD) begin
            r_rw    <= w_byte[7];
            r_addr  <= w_byte[6:0];
            r_state <= ST_DATA;
          end else begin
            r_state <= ST_HOLD;
            if (!r_rw && (r_addr <= ADDR_TPLSB)) begin
              r_stb     <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_byte;
              unique case (1'b1)
                (r_addr == ADDR_RESET): begin
                  if (w_byte[SOFT_RST_BIT]) begin
                    r_a1   <= REG_RST;
                    r_a2   <= REG_RST;
                    r_a3   <= REG_RST;
                    r_a4   <= REG_RST;
                    r_soft <= 1'b1;
                  end
                end
                (r_addr == ADDR_FORMAT):  r_a1 <= w_byte;
                (r_addr == ADDR_OUTMODE): r_a2 <= w_byte;
                (r_addr == ADDR_TPMSB):   r_a3 <= w_byte;
                (r_addr == ADDR_TPLSB):   r_a4 <= w_byte;
                default: ;
              endcase
            end
          end
        end
      end
      // A 16th edge seen together with cs rise has already committed above
      if (w_cs_rise) r_state <= ST_IDLE;
    end
  end

`ifdef LTC2174_SPI_READBACK_EN
  logic [7:0] w_rmux;
  logic [7:0] r_rd;
  logic       r_sdo;
  logic       r_oe;

  always_comb begin
    w_rmux = REG_RST;
    unique case (1'b1)
      (w_byte[6:0] == ADDR_FORMAT):  w_rmux = r_a1;
      (w_byte[6:0] == ADDR_OUTMODE): w_rmux = r_a2;
      (w_byte[6:0] == ADDR_TPMSB):   w_rmux = r_a3;
      (w_byte[6:0] == ADDR_TPLSB):   w_rmux = r_a4;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd  <= '0;
      r_sdo <= 1'b0;
      r_oe  <= 1'b0;
    end else if (w_cs_rise || w_cs_fall) begin
      r_sdo <= 1'b0;
      r_oe  <= 1'b0;
    end else if (w_sck_rise && r_state == ST_CMD && r_cnt == 3'd7) begin
      r_rd <= w_rmux;
    end else if (w_sck_fall && (r_oe || (r_state == ST_DATA && r_rw))) begin
      r_oe  <= 1'b1;
      r_sdo <= r_rd[7];
      r_rd  <= {r_rd[6:0], 1'b0};
    end
  end

  assign spi.sdo    = r_sdo;
  assign spi.sdo_oe = r_oe;
`else
  assign spi.sdo    = 1'b0;
  assign spi.sdo_oe = 1'b0;
`endif

  assign dcsoff      = r_a1[DCSOFF_BIT];
  assign rand_en     = r_a1[RAND_BIT];
  assign twoscomp    = r_a1[TWOS_BIT];
  assign sleep       = r_a1[SLEEP_W-1:0];
  assign ilvds       = r_a2[ILVDS_LSB +: ILVDS_W];
  assign termon      = r_a2[TERMON_BIT];
  assign outoff      = r_a2[OUTOFF_BIT];
  assign outmode     = r_a2[OUTMODE_W-1:0];
  assign outtest     = r_a3[OUTTEST_BIT];
  assign testpattern = {r_a3[TPMSB_W-1:0], r_a4};
  assign soft_reset  = r_soft;
  assign wr_stb      = r_stb;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;

endmodule
